mem_arbiter: RTL and testbench

- Shares one unified memory port between the core's instruction-fetch requester and data (load/store) requester.
- Sits between the 5-stage core and the single-ported memory model. Serialises requests as one outstanding transaction at a time.
- Data side has fixed priority, bounded by an instruction anti-starvation counter.
- Routes each response back to the requester that owns it.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which requester owns the in-flight transaction
//   mem_cmd_t   : latched memory command (we, be, addr, wdata)
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W   = 32;
  localparam int unsigned MEM_DATA_W   = 32;
  localparam int unsigned MEM_BE_W     = MEM_DATA_W / 8;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_BE_W-1:0]   be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: all handshake/bus signals around the arbiter.
//   i_* : instruction-fetch requester (req/addr in, gnt/rvalid/rdata out)
//   d_* : data requester (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   m_* : unified memory port (req/we/be/addr/wdata out, gnt/rvalid/rdata in)
// Modports:
//   slave  : the arbiter's view (serves the core requesters, drives memory)
//   master : the surrounding environment's view (core requesters + memory)
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) ();
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// requesters, one outstanding transaction at a time. Data has priority; an
// anti-starvation counter forces an instruction grant after STARVE_MAX
// consecutive data grants while a fetch is waiting.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mem_arbiter_if.slave, requester and memory handshakes
//   busy       : a transaction is in flight
// Optional (macro MEM_ARB_PERF_CNT_EN):
//   perf_i_stall, perf_d_stall : cycles a request waited without a grant
//   perf_starve_force          : forced instruction grants
// gnt/rvalid/rdata toward the requesters are combinational by design so the
// memory handshake is forwarded in the same cycle; all m_* and busy are flops.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_arbiter_if.slave       bus,
  output logic               busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_i_stall,
  output logic [31:0]        perf_d_stall,
  output logic [15:0]        perf_starve_force
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_REQ  = 2'(REQ);
  localparam logic [1:0] S_RESP = 2'(RESP);

  logic [1:0]              state_q, state_d;
  arb_owner_e              owner_q, owner_d;
  mem_cmd_t                cmd_q, cmd_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    m_req_q;
  logic                    busy_q;
  logic                    force_i;
  logic                    pick_d;
  logic                    grant_c;
  logic                    resp_c;

  // State, owner, command and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= NONE;
      cmd_q    <= '0;
      starve_q <= '0;
      m_req_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      starve_q <= starve_d;
      m_req_q  <= (state_d == S_REQ);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  // Next state, arbitration and command latch
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    grant_c = 1'b0;
    resp_c  = 1'b0;
    force_i = bus.i_req && bus.d_req && (starve_q == STARVE_CNT_W'(STARVE_MAX));
    pick_d  = bus.d_req && !force_i;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = S_REQ;
          if (pick_d) begin
            owner_d = OWN_D;
            cmd_d   = '{we:    bus.d_we,
                        be:    MEM_BE_W'(bus.d_be),
                        addr:  MEM_ADDR_W'(bus.d_addr),
                        wdata: MEM_DATA_W'(bus.d_wdata)};
          end else begin
            // Fetches are always full-word reads.
            owner_d = OWN_I;
            cmd_d   = '{we:    1'b0,
                        be:    '1,
                        addr:  MEM_ADDR_W'(bus.i_addr),
                        wdata: '0};
          end
        end
      end
      S_REQ: begin
        if (bus.m_gnt) begin
          grant_c = 1'b1;
          state_d = S_RESP;
          cmd_d   = '0;    // m_* read zero outside REQ
        end
      end
      S_RESP: begin
        if (bus.m_rvalid) begin
          resp_c  = 1'b1;
          state_d = S_IDLE;
          owner_d = NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = NONE;
        cmd_d   = '0;
      end
    endcase
  end

  // Anti-starvation: count data grants while a fetch keeps waiting
  always_comb begin
    starve_d = starve_q;
    if (!bus.i_req || (grant_c && owner_q == OWN_I)) begin
      starve_d = '0;
    end else if (grant_c && owner_q == OWN_D &&
                 starve_q != STARVE_CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + STARVE_CNT_W'(1);
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = cmd_q.we;
  assign bus.m_be    = BE_W'(cmd_q.be);
  assign bus.m_addr  = ADDR_W'(cmd_q.addr);
  assign bus.m_wdata = DATA_W'(cmd_q.wdata);
  assign busy        = busy_q;

  // Route handshakes back to the owner of the transaction
  assign bus.i_gnt    = grant_c && (owner_q == OWN_I);
  assign bus.d_gnt    = grant_c && (owner_q == OWN_D);
  assign bus.i_rvalid = resp_c && (owner_q == OWN_I);
  assign bus.d_rvalid = resp_c && (owner_q == OWN_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  // Stall and forced-grant counters, wrapping at their width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_stall      <= '0;
      perf_d_stall      <= '0;
      perf_starve_force <= '0;
    end else begin
      if (bus.i_req && !bus.i_gnt) perf_i_stall <= perf_i_stall + 32'd1;
      if (bus.d_req && !bus.d_gnt) perf_d_stall <= perf_d_stall + 32'd1;
      if (state_q == S_IDLE && force_i) perf_starve_force <= perf_starve_force + 16'd1;
    end
  end
`endif

  // Only one transaction is outstanding, so a response cannot overlap a grant.
  a_no_gnt_with_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == S_REQ && bus.m_gnt && bus.m_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter. Requesters
// and a memory with random grant/response delays are driven each cycle; a
// transaction-level reference model predicts every output.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_i_stall;
  logic [31:0] perf_d_stall;
  logic [15:0] perf_starve_force;
`endif

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_i_stall      (perf_i_stall),
    .perf_d_stall      (perf_d_stall),
    .perf_starve_force (perf_starve_force)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the single transaction the arbiter currently holds
  bit                t_valid, t_granted, t_is_d, t_we;
  logic [BE_W-1:0]   t_be;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  int unsigned       starve;
  logic [31:0]       p_i_stall, p_d_stall;
  logic [15:0]       p_force;

  // Stimulus bookkeeping
  bit          i_drop, d_drop, mem_waiting;
  bit          track_runs, seen_i;
  int unsigned d_run;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
  endtask

  task automatic model_reset();
    t_valid   = 1'b0;
    t_granted = 1'b0;
    starve    = 0;
    p_i_stall = '0;
    p_d_stall = '0;
    p_force   = '0;
    i_drop    = 1'b0;
    d_drop    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   busy,                         0);
    check({tag, "_m_req"},  bus.m_req,                    0);
    check({tag, "_m_addr"}, bus.m_addr,                   0);
    check({tag, "_m_cmd"},  {bus.m_we, bus.m_be, bus.m_wdata}, 0);
    check({tag, "_gnt"},    {bus.i_gnt, bus.d_gnt},       0);
    check({tag, "_rvalid"}, {bus.i_rvalid, bus.d_rvalid}, 0);
    check({tag, "_rdata"},  {bus.i_rdata, bus.d_rdata},   0);
  endtask

  // One clock cycle: drive requesters and memory, check outputs, advance model
  task automatic cycle(input int unsigned gnt_pct, input int unsigned rv_pct,
                       input int unsigned ireq_pct, input int unsigned dreq_pct);
    bit exp_mreq, exp_ig, exp_dg, exp_irv, exp_drv, forced;
    @(posedge clk);
    #1;
    // Requesters: withdraw after a grant, then maybe issue a new request
    if (i_drop) bus.i_req = 1'b0;
    if (d_drop) bus.d_req = 1'b0;
    i_drop = 1'b0;
    d_drop = 1'b0;
    if (!bus.i_req && $urandom_range(99) < ireq_pct) begin
      bus.i_req  = 1'b1;
      bus.i_addr = ADDR_W'($urandom);
    end
    if (!bus.d_req && $urandom_range(99) < dreq_pct) begin
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom);
      bus.d_be    = BE_W'($urandom_range(1, 15));
      bus.d_addr  = ADDR_W'($urandom);
      bus.d_wdata = DATA_W'($urandom);
    end
    // Memory: grant on request, answer some cycles later, stray rvalid when idle
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = DATA_W'($urandom);
    if (mem_waiting) begin
      if ($urandom_range(99) < rv_pct) begin
        bus.m_rvalid = 1'b1;
        mem_waiting  = 1'b0;
      end
    end else if (bus.m_req) begin
      if ($urandom_range(99) < gnt_pct) begin
        bus.m_gnt   = 1'b1;
        mem_waiting = 1'b1;
      end
    end else if ($urandom_range(99) < 10) begin
      bus.m_rvalid = 1'b1;
    end

    @(negedge clk);
    exp_mreq = t_valid && !t_granted;
    exp_ig   = exp_mreq && bus.m_gnt && !t_is_d;
    exp_dg   = exp_mreq && bus.m_gnt && t_is_d;
    exp_irv  = t_valid && t_granted && bus.m_rvalid && !t_is_d;
    exp_drv  = t_valid && t_granted && bus.m_rvalid && t_is_d;

    check("busy",     busy,         t_valid);
    check("m_req",    bus.m_req,    exp_mreq);
    check("m_addr",   bus.m_addr,   exp_mreq ? t_addr : '0);
    check("m_cmd",    {bus.m_we, bus.m_be, bus.m_wdata}, exp_mreq ? {t_we, t_be, t_wdata} : '0);
    check("i_gnt",    bus.i_gnt,    exp_ig);
    check("d_gnt",    bus.d_gnt,    exp_dg);
    check("i_rvalid", bus.i_rvalid, exp_irv);
    check("d_rvalid", bus.d_rvalid, exp_drv);
    check("i_rdata",  bus.i_rdata,  exp_irv ? bus.m_rdata : '0);
    check("d_rdata",  bus.d_rdata,  exp_drv ? bus.m_rdata : '0);
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_i_stall",      perf_i_stall,      p_i_stall);
    check("perf_d_stall",      perf_d_stall,      p_d_stall);
    check("perf_starve_force", perf_starve_force, p_force);
`endif

    // Under saturating load, exactly STARVE_MAX data grants separate fetches
    if (track_runs) begin
      if (bus.d_gnt) d_run++;
      if (bus.i_gnt) begin
        if (seen_i) check("starve_run", d_run, STARVE_MAX);
        seen_i = 1'b1;
        d_run  = 0;
      end
    end

    // Advance the model to the next cycle
    if (!t_valid) begin
      if (bus.i_req || bus.d_req) begin
        forced    = bus.i_req && bus.d_req && (starve == STARVE_MAX);
        t_valid   = 1'b1;
        t_granted = 1'b0;
        if (forced) p_force = p_force + 16'd1;
        if (bus.d_req && !forced) begin
          t_is_d  = 1'b1;
          t_we    = bus.d_we;
          t_be    = bus.d_be;
          t_addr  = bus.d_addr;
          t_wdata = bus.d_wdata;
        end else begin
          t_is_d  = 1'b0;
          t_we    = 1'b0;
          t_be    = '1;
          t_addr  = bus.i_addr;
          t_wdata = '0;
        end
      end
    end else if (exp_mreq && bus.m_gnt) begin
      t_granted = 1'b1;
    end else if (exp_irv || exp_drv) begin
      t_valid = 1'b0;
    end
    if (!bus.i_req || exp_ig) starve = 0;
    else if (exp_dg && starve < STARVE_MAX) starve++;
    if (bus.i_req && !exp_ig) p_i_stall = p_i_stall + 32'd1;
    if (bus.d_req && !exp_dg) p_d_stall = p_d_stall + 32'd1;

    i_drop = bus.i_gnt;
    d_drop = bus.d_gnt;
  endtask

  // Reset while waiting for a response; the late response must be dropped
  task automatic reset_in_resp();
    int unsigned guard = 0;
    while (!(t_valid && t_granted) && guard < 200) begin
      cycle(100, 0, 60, 60);
      guard++;
    end
    check("resp_reached", guard < 200, 1);
    check("resp_busy", busy, 1);
    rst_n        = 1'b0;
    bus.i_req    = 1'b0;
    bus.d_req    = 1'b0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    // mem_waiting is still set, so the memory answers now, into IDLE
    repeat (6) cycle(100, 100, 0, 0);
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_gnt   = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata = '0;
    mem_waiting = 1'b0;
    track_runs  = 1'b0;
    seen_i      = 1'b0;
    d_run       = 0;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
`ifdef MEM_ARB_PERF_CNT_EN
    check("reset_perf", {perf_i_stall, perf_d_stall, perf_starve_force}, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (600) cycle(70, 60, 40, 40);   // mixed traffic
    repeat (300) cycle(20, 30, 50, 50);   // slow memory, long REQ holds
    track_runs = 1'b1;
    repeat (300) cycle(100, 100, 100, 100);
    track_runs = 1'b0;
    repeat (200) cycle(100, 100, 30, 90); // data-heavy
    reset_in_resp();
    repeat (300) cycle(60, 60, 50, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
